seg10_scan_ctrl: RTL and testbench
==================================

// Module: seg10_scan_ctrl
// PURPOSE
//  Time-multiplexed scan scheduler. Shares one seg10 decoder and its 10 segment lines
//  across NUM_DIGITS common-driven digits.
//  - Walks digits in a fixed round-robin, one slot per digit.
//  - Inserts a blanking gap between digits to prevent ghosting.
//  - Applies 16-level PWM brightness.
//  - Double-buffers digit values so a frame never tears.
//  Sits between the encoder/counter logic and seg10: seg_count feeds seg10.count.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; 2..8
//  SCAN_DIV      12000  clk cycles a digit is shown per slot; multiple of 16, >=16
//  BLANK_CYCLES  120    clk cycles all digits are off before each slot; >=1
// PORTS
//  clk           in   1             system clock, all logic on posedge
//  rst_n         in   1             asynchronous, active-low reset
//  digit_values  in   4*NUM_DIGITS  nibble i = value of digit i (bits 4i+3:4i)
//  digit_enable  in   NUM_DIGITS    bit i=0: digit i kept dark, its slot still consumed
//  load          in   1             1-cycle strobe: capture digit_values into staging
//  brightness    in   4             0=off .. 15=15/16 duty within the show phase
//  seg_count     out  4             value presented to seg10 decoder
//  seg_blank     out  1             1 = segment drivers must be off
//  digit_sel     out  NUM_DIGITS    one-hot active-high digit drive; all-zero when dark
//  frame_done    out  1             1-cycle pulse at the end of the last digit's slot
// BEHAVIOUR
//  - Reset: all outputs registered and cleared.
//    - seg_count=0, seg_blank=1, digit_sel=0, frame_done=0.
//    - State=BLANK, idx=0, counters=0.
//    - Staging, shadow, pending and bright_q all cleared.
//  - FSM BLANK: runs BLANK_CYCLES cycles with digit_sel=0 and seg_blank=1.
//    - On the last cycle: bright_q <= brightness, then go to SHOW.
//  - FSM SHOW: runs SCAN_DIV cycles, show_cnt = 0..SCAN_DIV-1.
//    - lit = (show_cnt / (SCAN_DIV/16)) < bright_q.
//    - seg_count = shadow[idx] for the whole phase.
//    - digit_sel = onehot(idx) if digit_enable[idx] && lit, else 0.
//    - seg_blank = ~(digit_enable[idx] && lit).
//    - On the last cycle: go to BLANK and advance idx; NUM_DIGITS-1 wraps to 0.
//  - Latency: outputs update on the clock edge that enters or advances the phase.
//    digit_sel and seg_blank always change on the same edge.
//    seg_count never changes while digit_sel != 0.
//  - Slot/frame timing:
//    - Slot = BLANK_CYCLES+SCAN_DIV cycles.
//    - Frame = NUM_DIGITS slots, constant regardless of enables or brightness.
//  - brightness is sampled only at the BLANK->SHOW transition.
//    A mid-slot change takes effect from the next slot.
//  - Double buffering:
//    - load: staging <= digit_values and pending <= 1. A later load overwrites staging (last wins).
//    - At the end of the last digit's SHOW cycle, frame_done=1. If pending: shadow <= staging, pending <= 0.
//    - load on that same cycle: shadow <= digit_values directly, pending stays 0.
//  - First frame after reset displays zeros unless a load arrives before that frame ends.
//  - Mid-operation reset: immediately dark (seg_blank=1, digit_sel=0). Restarts at digit 0 in BLANK.
//  - digit_enable and digit_values are assumed synchronous to clk; there are no internal synchronisers.
// STRUCTURE
//  - Shared package: state encoding (ST_BLANK, ST_SHOW), PWM_LEVELS=16, log2 helper for idx/counters.
//  - One sub-module: seg10_pwm_slot.
//    - Takes show_cnt and bright_q; returns lit.
//    - Contains the SCAN_DIV/16 step divider.
//  - Top level holds the FSM, idx counter, staging/shadow registers and output registers.
// TESTING  (NUM_DIGITS=2, SCAN_DIV=32, BLANK_CYCLES=2, all enables=1)
//  - Reset release, brightness=15 -> 2 cycles dark.
//    Then digit_sel=2'b01, lit for 30 cycles, dark for 2.
//    Then 2 blank cycles, then digit_sel=2'b10. frame_done pulses every 68 cycles.
//  - load digit_values=8'h93 in slot 0 -> digits show 0,0 until frame_done.
//    Next frame shows digit0=3, digit1=9.
//  - Two loads (8'h11 then 8'h22) within one frame -> next frame shows 2,2.
//    load coincident with frame_done -> value appears the next frame.
//  - brightness=0 -> digit_sel=0 and seg_blank=1 always.
//    brightness=8 -> lit exactly 16 of 32 show cycles per slot.
//    Change brightness mid-SHOW -> duty changes from the next slot only.
//  - digit_enable=2'b10 -> slot 0 dark but still 34 cycles long. Frame period unchanged at 68.
//  - Assert rst_n=0 mid-SHOW of digit 1 -> outputs dark asynchronously.
//    After release, restarts at BLANK of digit 0 with shadow=0.

Source files
------------

// File: rtl/seg10_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg10_scan_ctrl_pkg                                                  |
// | Shared types and helpers for the seg10 digit scan scheduler.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package seg10_scan_ctrl_pkg;

  // Scan phase: all digits dark, or one digit being shown.
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Brightness resolution; the show phase is split into this many steps.
  localparam int PWM_LEVELS = 16;
  localparam int BRIGHT_W   = 4;

  // Bits needed for a counter running 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg10_pwm_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg10_pwm_slot                                                       |
// | Decides whether the current show cycle is inside the lit part of     |
// | the brightness duty: step = SCAN_DIV/16, lit = step index < bright.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seg10_pwm_slot
  import seg10_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 12000,
  parameter int CNT_W    = cnt_width(SCAN_DIV)
) (
  input  logic [CNT_W-1:0]    show_cnt_i,
  input  logic [BRIGHT_W-1:0] bright_i,
  output logic                lit_o
);

  localparam int               STEP   = SCAN_DIV / PWM_LEVELS;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  logic [CNT_W-1:0] level;

  // Map the show counter onto one of the 16 duty steps and compare to brightness.
  always_comb begin
    level = show_cnt_i / STEP_C;
    lit_o = (level < CNT_W'(bright_i));
  end

endmodule
`default_nettype wire

// File: rtl/seg10_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg10_scan_ctrl                                                      |
// | Round-robin scan scheduler sharing one seg10 decoder across          |
// | NUM_DIGITS digits, with blanking gaps, 16-level PWM brightness and   |
// | frame-synchronous double buffering of the digit values.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seg10_scan_ctrl
  import seg10_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] digit_values_i,
  input  logic [NUM_DIGITS-1:0]   digit_enable_i,
  input  logic                    load_i,
  input  logic [3:0]              brightness_i,
  output logic [3:0]              seg_count_o,
  output logic                    seg_blank_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_done_o
);

  localparam int IDX_W   = cnt_width(NUM_DIGITS);
  localparam int SHOW_W  = cnt_width(SCAN_DIV);
  localparam int BLANK_W = cnt_width(BLANK_CYCLES);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SCAN_DIV - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SHOW_W-1:0]       show_cnt_q, show_cnt_d;
  logic [BLANK_W-1:0]      blank_cnt_q, blank_cnt_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  logic [3:0]              seg_count_q, seg_count_d;
  logic                    seg_blank_q, seg_blank_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    frame_done_q, frame_done_d;

  logic                    frame_end;
  logic                    lit;
  logic                    drive_on;

  // Duty decision is made for the cycle being entered, so outputs can be registered.
  seg10_pwm_slot #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (SHOW_W)
  ) u_pwm (
    .show_cnt_i (show_cnt_d),
    .bright_i   (bright_d),
    .lit_o      (lit)
  );

  // Phase sequencing, digit index and the staging/shadow double buffer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    show_cnt_d  = show_cnt_q;
    blank_cnt_d = blank_cnt_q;
    bright_d    = bright_q;
    staging_d   = staging_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;

    frame_end = (state_q == ST_SHOW) && (show_cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);

    case (state_q)
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d     = ST_SHOW;
          blank_cnt_d = '0;
          show_cnt_d  = '0;
          bright_d    = brightness_i;
        end else begin
          blank_cnt_d = blank_cnt_q + BLANK_W'(1);
        end
      end
      default: begin
        if (show_cnt_q == SHOW_LAST) begin
          state_d    = ST_BLANK;
          show_cnt_d = '0;
          idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          show_cnt_d = show_cnt_q + SHOW_W'(1);
        end
      end
    endcase

    if (load_i) begin
      staging_d = digit_values_i;
    end

    // A load landing on the frame boundary bypasses staging so it is not lost.
    if (frame_end) begin
      pending_d = 1'b0;
      if (load_i) begin
        shadow_d = digit_values_i;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  // Output values for the cycle being entered; seg_count only moves at show entry.
  always_comb begin
    drive_on     = (state_d == ST_SHOW) && digit_enable_i[idx_d] && lit;
    digit_sel_d  = drive_on ? (NUM_DIGITS'(1) << idx_d) : '0;
    seg_blank_d  = ~drive_on;
    frame_done_d = (state_d == ST_SHOW) && (show_cnt_d == SHOW_LAST) && (idx_d == IDX_LAST);
    seg_count_d  = seg_count_q;
    if ((state_q == ST_BLANK) && (state_d == ST_SHOW)) begin
      seg_count_d = shadow_q[{idx_d, 2'b00} +: 4];
    end
  end

  // Single state/output register bank; reset forces everything dark at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      show_cnt_q   <= '0;
      blank_cnt_q  <= '0;
      bright_q     <= '0;
      staging_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      seg_count_q  <= '0;
      seg_blank_q  <= 1'b1;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      show_cnt_q   <= show_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      bright_q     <= bright_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_count_q  <= seg_count_d;
      seg_blank_q  <= seg_blank_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_count_o  = seg_count_q;
  assign seg_blank_o  = seg_blank_q;
  assign digit_sel_o  = digit_sel_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg10_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg10_scan_ctrl                                                   |
// | Slot-by-slot directed bench for seg10_scan_ctrl (2 digits,           |
// | SCAN_DIV=32, BLANK_CYCLES=2, slot = 34 cycles, frame = 68 cycles).   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_seg10_scan_ctrl;

  localparam int ND   = 2;
  localparam int SLOT = 34;

  logic       clk;
  logic       rst_n;
  logic [7:0] digit_values;
  logic [1:0] digit_enable;
  logic       load;
  logic [3:0] brightness;
  logic [3:0] seg_count;
  logic       seg_blank;
  logic [1:0] digit_sel;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  seg10_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (32),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .digit_values_i (digit_values),
    .digit_enable_i (digit_enable),
    .load_i         (load),
    .brightness_i   (brightness),
    .seg_count_o    (seg_count),
    .seg_blank_o    (seg_blank),
    .digit_sel_o    (digit_sel),
    .frame_done_o   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scan slot: stimulus applied at slot offsets, expected observations.
  typedef struct {
    logic [3:0] bright;
    logic [1:0] en;
    int         load_at;
    logic [7:0] load_val;
    int         load2_at;
    logic [7:0] load2_val;
    int         bchg_at;
    logic [3:0] bchg_val;
    int         exp_lit;
    logic [1:0] exp_sel;
    logic [3:0] exp_cnt;
    int         exp_fd;
  } slot_t;

  slot_t tbl[12];

  function automatic slot_t mk(input logic [3:0] b, input logic [1:0] en,
                               input int la, input logic [7:0] lv,
                               input int la2, input logic [7:0] lv2,
                               input int bc, input logic [3:0] bv,
                               input int el, input logic [1:0] es,
                               input logic [3:0] ec, input int ef);
    slot_t s;
    s.bright = b;   s.en = en;
    s.load_at = la; s.load_val = lv; s.load2_at = la2; s.load2_val = lv2;
    s.bchg_at = bc; s.bchg_val = bv;
    s.exp_lit = el; s.exp_sel = es; s.exp_cnt = ec; s.exp_fd = ef;
    return s;
  endfunction

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Runs 34 cycles starting at the first BLANK cycle of a slot.
  // Offset 0,1 = blank, offsets 2..33 = show counter 0..31.
  task automatic run_slot(input string name, input slot_t r);
    int         lit_n     = 0;
    int         win_bad   = 0;
    int         cnt_bad   = 0;
    int         blank_bad = 0;
    int         fd_n      = 0;
    int         fd_pos    = -1;
    logic [1:0] sel_or    = 2'b00;
    logic [3:0] cnt_seen  = r.exp_cnt;
    for (int c = 0; c < SLOT; c++) begin
      if (digit_sel != 2'b00) begin
        lit_n++;
        sel_or |= digit_sel;
        if (c < 2 || c >= 2 + r.exp_lit) win_bad++;
      end
      if (c >= 2 && seg_count !== r.exp_cnt) begin
        cnt_bad++;
        cnt_seen = seg_count;
      end
      if (frame_done === 1'b1) begin
        fd_n++;
        fd_pos = c;
      end
      if (seg_blank !== (digit_sel == 2'b00)) blank_bad++;
      if (c == 0) begin
        brightness   = r.bright;
        digit_enable = r.en;
      end
      if (c == r.bchg_at) brightness = r.bchg_val;
      load         = (c == r.load_at) || (c == r.load2_at);
      digit_values = (c == r.load2_at) ? r.load2_val : r.load_val;
      @(negedge clk);
    end
    load = 1'b0;
    check({name, " lit_count"}, lit_n == r.exp_lit,
          $sformatf("got %0d want %0d", lit_n, r.exp_lit));
    check({name, " lit_window"}, win_bad == 0,
          $sformatf("got %0d lit cycles outside offsets 2..%0d want 0", win_bad, 1 + r.exp_lit));
    check({name, " digit_sel"}, sel_or == r.exp_sel,
          $sformatf("got %b want %b", sel_or, r.exp_sel));
    check({name, " seg_count"}, cnt_bad == 0,
          $sformatf("got %h on %0d cycles want %h", cnt_seen, cnt_bad, r.exp_cnt));
    check({name, " frame_done"}, (fd_n == r.exp_fd) && (r.exp_fd == 0 || fd_pos == SLOT - 1),
          $sformatf("got %0d pulses last at %0d want %0d at %0d", fd_n, fd_pos, r.exp_fd, SLOT - 1));
    check({name, " blank_vs_sel"}, blank_bad == 0,
          $sformatf("got %0d inconsistent cycles want 0", blank_bad));
  endtask

  initial begin
    rst_n        = 1'b0;
    digit_values = 8'h00;
    digit_enable = 2'b11;
    load         = 1'b0;
    brightness   = 4'd15;

    //            br  en     ld  val    ld2 val2   bc  bv   lit sel    cnt  fd
    tbl[0]  = mk(15, 2'b11,  5, 8'h93, -1, 8'h00, -1, 0,  30, 2'b01, 0, 0); // load hidden until frame end
    tbl[1]  = mk(15, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0,  30, 2'b10, 0, 1);
    tbl[2]  = mk(15, 2'b11,  3, 8'h11, -1, 8'h00, -1, 0,  30, 2'b01, 3, 0); // 93 now shown
    tbl[3]  = mk(15, 2'b11, 20, 8'h22, -1, 8'h00, -1, 0,  30, 2'b10, 9, 1);
    tbl[4]  = mk( 8, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0,  16, 2'b01, 2, 0); // last load (22) wins
    tbl[5]  = mk( 8, 2'b11, -1, 8'h00, 33, 8'h5A, -1, 0,  16, 2'b10, 2, 1); // load on frame_done
    tbl[6]  = mk( 0, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0,   0, 2'b00, 4'hA, 0);
    tbl[7]  = mk( 0, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0,   0, 2'b00, 5, 1);
    tbl[8]  = mk(15, 2'b10, -1, 8'h00, -1, 8'h00, -1, 0,   0, 2'b00, 4'hA, 0); // disabled slot keeps length
    tbl[9]  = mk(15, 2'b10, -1, 8'h00, -1, 8'h00, -1, 0,  30, 2'b10, 5, 1);
    tbl[10] = mk(15, 2'b11, -1, 8'h00, -1, 8'h00, 10, 4,  30, 2'b01, 4'hA, 0); // mid-show change ignored
    tbl[11] = mk( 4, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0,   8, 2'b10, 5, 1);

    repeat (3) @(negedge clk);
    check("reset seg_count",  seg_count === 4'h0,  $sformatf("got %h want 0", seg_count));
    check("reset seg_blank",  seg_blank === 1'b1,  $sformatf("got %b want 1", seg_blank));
    check("reset digit_sel",  digit_sel === 2'b00, $sformatf("got %b want 00", digit_sel));
    check("reset frame_done", frame_done === 1'b0, $sformatf("got %b want 0", frame_done));

    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_slot($sformatf("slot%0d", i), tbl[i]);
    end

    // Digit 0 of another frame, then reset part way through digit 1's show phase.
    run_slot("slot12", mk(15, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0, 30, 2'b01, 4'hA, 0));
    repeat (15) @(negedge clk);
    check("pre_reset digit_sel", digit_sel === 2'b10, $sformatf("got %b want 10", digit_sel));
    check("pre_reset seg_count", seg_count === 4'h5,  $sformatf("got %h want 5", seg_count));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset digit_sel", digit_sel === 2'b00, $sformatf("got %b want 00", digit_sel));
    check("async_reset seg_blank", seg_blank === 1'b1,  $sformatf("got %b want 1", seg_blank));
    check("async_reset frame_done", frame_done === 1'b0, $sformatf("got %b want 0", frame_done));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_slot("post_reset0", mk(15, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0, 30, 2'b01, 0, 0));
    run_slot("post_reset1", mk(15, 2'b11, -1, 8'h00, -1, 8'h00, -1, 0, 30, 2'b10, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
